// File: rtl/fpga_robots_game_tmarb.sv
// fpga_robots_game_tmarb
// Tile map access arbiter. Two requesters (A: game logic, B: host serial
// command) share a single tile map port, with round-robin arbitration between
// them. A clear engine has priority over both: it fills addresses 0..CLR_LAST
// with one tile code, writing one address per cycle. All outputs are
// registered, and at most one tile map access is issued per cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   x_req/x_wen/x_adr/x_wrt   request, write flag, address and write data
//                             (x = a, b); the fields are held until x_ack
//   x_ack               1-cycle grant pulse, one cycle after the grant decision
//   x_rdv/x_rdd         read data valid pulse and read data (held between pulses)
//   clr_go/clr_val      start-clear pulse and the tile code to fill with
//   clr_busy            clear in progress
//   tm_adr/tm_wrt/tm_wen      tile map access; adr/wrt hold when idle
//   tm_red              tile map read data, sampled the cycle after tm_adr
//
// Clear FSM
//   state   | meaning
//   S_IDLE  | arbitrating A/B; clr_go starts a clear
//   S_CLEAR | one clear write per cycle; A/B not granted, clr_go ignored
module fpga_robots_game_tmarb #(
  parameter logic [12:0] CLR_LAST = 13'd8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_wen,
  input  logic [12:0] a_adr,
  input  logic [7:0]  a_wrt,
  output logic        a_ack,
  output logic        a_rdv,
  output logic [7:0]  a_rdd,
  input  logic        b_req,
  input  logic        b_wen,
  input  logic [12:0] b_adr,
  input  logic [7:0]  b_wrt,
  output logic        b_ack,
  output logic        b_rdv,
  output logic [7:0]  b_rdd,
  input  logic        clr_go,
  input  logic [7:0]  clr_val,
  output logic        clr_busy,
  output logic [12:0] tm_adr,
  output logic [7:0]  tm_wrt,
  output logic        tm_wen,
  input  logic [7:0]  tm_red
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t      r_state, w_state_nx;
  logic [12:0] r_clr_adr, w_clr_adr_nx;
  logic [7:0]  r_clr_val, w_clr_val_nx;
  logic        r_prio_b, w_prio_b_nx;   // 1: B wins the next contention
  logic        w_a_elig, w_b_elig, w_gnt_a, w_gnt_b;
  logic        w_iss, w_iss_wen;
  logic [12:0] w_iss_adr;
  logic [7:0]  w_iss_wrt;

  logic [12:0] r_tm_adr;
  logic [7:0]  r_tm_wrt, r_a_rdd, r_b_rdd;
  logic        r_tm_wen, r_a_ack, r_b_ack, r_a_rd, r_b_rd, r_a_rdv, r_b_rdv;
  logic        r_clr_busy;

  // A requester is ineligible in its own ack cycle; still-high req in the
  // cycle after is a new access.
  assign w_a_elig = a_req & ~r_a_ack;
  assign w_b_elig = b_req & ~r_b_ack;

  always_comb begin
    w_state_nx   = r_state;
    w_clr_adr_nx = r_clr_adr;
    w_clr_val_nx = r_clr_val;
    w_prio_b_nx  = r_prio_b;
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    w_iss        = 1'b0;
    w_iss_wen    = 1'b0;
    w_iss_adr    = r_tm_adr;
    w_iss_wrt    = r_tm_wrt;
    case (r_state)
      S_IDLE: begin
        if (clr_go) begin
          // clear beats any pending request; address 0 goes out with clr_busy
          w_state_nx   = S_CLEAR;
          w_clr_val_nx = clr_val;
          w_clr_adr_nx = 13'd0;
          w_iss        = 1'b1;
          w_iss_wen    = 1'b1;
          w_iss_adr    = 13'd0;
          w_iss_wrt    = clr_val;
        end else if (w_a_elig && (!w_b_elig || !r_prio_b)) begin
          w_gnt_a     = 1'b1;
          w_prio_b_nx = 1'b1;
          w_iss       = 1'b1;
          w_iss_wen   = a_wen;
          w_iss_adr   = a_adr;
          w_iss_wrt   = a_wrt;
        end else if (w_b_elig) begin
          w_gnt_b     = 1'b1;
          w_prio_b_nx = 1'b0;
          w_iss       = 1'b1;
          w_iss_wen   = b_wen;
          w_iss_adr   = b_adr;
          w_iss_wrt   = b_wrt;
        end
      end
      S_CLEAR: begin
        // r_clr_adr is the address on tm_adr this cycle; stop without wrapping
        if (r_clr_adr == CLR_LAST) begin
          w_state_nx = S_IDLE;
        end else begin
          w_clr_adr_nx = r_clr_adr + 13'd1;
          w_iss        = 1'b1;
          w_iss_wen    = 1'b1;
          w_iss_adr    = r_clr_adr + 13'd1;
          w_iss_wrt    = r_clr_val;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_clr_adr  <= 13'd0;
      r_clr_val  <= 8'd0;
      r_prio_b   <= 1'b0;
      r_clr_busy <= 1'b0;
      r_tm_adr   <= 13'd0;
      r_tm_wrt   <= 8'd0;
      r_tm_wen   <= 1'b0;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_rd     <= 1'b0;
      r_b_rd     <= 1'b0;
      r_a_rdv    <= 1'b0;
      r_b_rdv    <= 1'b0;
      r_a_rdd    <= 8'd0;
      r_b_rdd    <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_clr_adr  <= w_clr_adr_nx;
      r_clr_val  <= w_clr_val_nx;
      r_prio_b   <= w_prio_b_nx;
      r_clr_busy <= (w_state_nx == S_CLEAR);
      r_tm_wen   <= w_iss & w_iss_wen;
      if (w_iss) begin
        r_tm_adr <= w_iss_adr;
        r_tm_wrt <= w_iss_wrt;
      end
      r_a_ack <= w_gnt_a;
      r_b_ack <= w_gnt_b;
      // read in flight: tm_red is sampled one cycle after the address goes out
      r_a_rd  <= w_gnt_a & ~a_wen;
      r_b_rd  <= w_gnt_b & ~b_wen;
      r_a_rdv <= r_a_rd;
      r_b_rdv <= r_b_rd;
      if (r_a_rd) r_a_rdd <= tm_red;
      if (r_b_rd) r_b_rdd <= tm_red;
    end
  end

  assign tm_adr   = r_tm_adr;
  assign tm_wrt   = r_tm_wrt;
  assign tm_wen   = r_tm_wen;
  assign a_ack    = r_a_ack;
  assign b_ack    = r_b_ack;
  assign a_rdv    = r_a_rdv;
  assign b_rdv    = r_b_rdv;
  assign a_rdd    = r_a_rdd;
  assign b_rdd    = r_b_rdd;
  assign clr_busy = r_clr_busy;

endmodule
